lc3_controller: RTL and testbench
=================================

# lc3_controller

Multicycle control FSM for the LC3 microcontroller. It consumes the control_in signal bundle and drives the control_out enables that sequence the datapath through fetch, decode, execute, memory, writeback and PC update. It sits between the fetch/decode/execute/writeback/memaccess units and is the active end of the bundle the control_in agent observes.

## Interface

- TIMEOUT_CYCLES, 16: maximum wait cycles for complete_instr/complete_data; legal range 2..255. Used only with LC3_CTRL_TIMEOUT_EN.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- complete_instr  in  1  instruction memory access done
- complete_data  in  1  data memory access done
- IR  in  16  decoded instruction; unused by the FSM
- IR_Exec  in  16  instruction in execute; opcode IR_Exec[15:12] and condition field IR_Exec[11:9]
- NZP  in  3  condition codes {N,Z,P}
- psr  in  3  accepted for bundle completeness; no effect
- IMem_dout  in  16  accepted for bundle completeness; no effect
- enable_fetch  out  1
- enable_decode  out  1
- enable_execute  out  1
- enable_writeback  out  1
- enable_updatePC  out  1
- br_taken  out  1  PC loads target; valid only while enable_updatePC=1
- mem_state  out  2  0=read, 1=indirect read, 2=write, 3=idle
- illegal_op  out  1  one-cycle pulse
- timeout  out  1  one-cycle pulse

## Operation

- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, UPC. Internal ind_phase flag. 4-bit opcode register loaded from IR_Exec[15:12] on the edge that leaves EXEC.
- Outputs are Moore decodes of the registered state. Each enable is high only in its state: FETCH→enable_fetch, DECODE→enable_decode, EXEC→enable_execute, WB→enable_writeback, UPC→enable_updatePC. illegal_op and timeout are registered.
- IDLE → FETCH on the first edge after reset release.
- FETCH: holds until complete_instr=1 at an edge, then → DECODE.
- DECODE → EXEC after 1 cycle.
- EXEC → next state by opcode:
  - ADD 0001, AND 0101, NOT 1001, LEA 1110 → WB.
  - LD 0010, LDR 0110, ST 0011, STR 0111 → MEM with ind_phase=0.
  - LDI 1010, STI 1011 → MEM with ind_phase=1.
  - BR 0000, JMP 1100 → UPC.
  - Any other opcode (1000, 1101, 1111, 0100) → UPC; illegal_op pulses high during that UPC cycle.
- MEM mem_state: ind_phase=1 → 1; otherwise loads → 0 and stores → 2. Outside MEM, mem_state=3.
  - complete_data=1 with ind_phase=1 → stay in MEM and clear ind_phase.
  - complete_data=1 with ind_phase=0 → loads go to WB, stores go to UPC.
- WB → UPC after 1 cycle.
- UPC → FETCH after 1 cycle. br_taken: BR → |(IR_Exec[11:9] & NZP); JMP → 1; otherwise 0.

## Timing

- Reset low, asynchronously and including mid-instruction: state=IDLE, ind_phase=0, all enables=0, br_taken=0, mem_state=3, illegal_op=0, timeout=0. Any in-progress access is abandoned.
- Minimum ALU instruction is 5 cycles (FETCH, DECODE, EXEC, WB, UPC). Minimum LD is 6 cycles, ST 5, LDI 7, BR 4.
- complete_* is sampled only in its wait state; assertion in any other state is ignored. Complete high on the first wait cycle gives a 1-cycle wait.
- IR_Exec and NZP must be stable from EXEC through UPC.

## Configuration

- LC3_CTRL_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to FETCH and to each MEM phase, and increments every wait cycle with complete low.
  - If complete is low at the edge where the counter equals TIMEOUT_CYCLES-1, the FSM goes to UPC with br_taken=0 and timeout pulses high for that UPC cycle.
- Not defined: no counter; the FSM waits indefinitely; timeout is tied 0.

## Test plan

- Reset release, IR_Exec=x1042 (ADD), complete_instr=1 → enables assert one per cycle in order fetch, decode, execute, writeback, updatePC, then fetch again; br_taken=0; mem_state=3 throughout.
- IR_Exec=x2205 (LD), complete_data low 3 cycles then high → mem_state=0 for 4 cycles, then writeback, then updatePC. Repeat with x3205 (ST): mem_state=2 for 4 cycles, then straight to updatePC.
- IR_Exec=xA200 (LDI), complete_data high 1 cycle in each phase → mem_state 1, then 0, then writeback. Repeat with xB200 (STI): mem_state 1, then 2.
- IR_Exec=x0402 (BRz) with NZP=010 → br_taken=1 in UPC. Same with NZP=100 → br_taken=0. IR_Exec=xC1C0 (JMP) → br_taken=1.
- IR_Exec=xF025 (TRAP) → illegal_op=1 coincident with enable_updatePC, br_taken=0. Separately, drop reset during MEM → all outputs at reset values immediately; FETCH resumes one cycle after release.
- LC3_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, ST with complete_data held 0 → 16 MEM cycles, then timeout=1 with enable_updatePC. Without the macro, the FSM is still in MEM after 100 cycles.

Source files
------------

// File: rtl/lc3_controller.sv
// LC3 multicycle control FSM: sequences fetch, decode, execute, memory, writeback and PC update.
// Optional wait-state timeout on complete_instr/complete_data is built in when LC3_CTRL_TIMEOUT_EN is defined.
module lc3_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    input  logic [15:0] IMem_dout,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        illegal_op,
    output logic        timeout,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_UPC    = 3'd6
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    state_t     state_q, state_d;
    logic       ind_q, ind_d;
    logic [3:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic       wait_expired;
    logic [3:0] exec_op;
    logic       unused_inputs;

    assign exec_op       = IR_Exec[15:12];
    assign unused_inputs = ^{IR, psr, IMem_dout, IR_Exec[8:0]};

    function automatic logic op_is_alu(input logic [3:0] op);
        return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return op inside {OP_LD, OP_LDR, OP_ST, OP_STR, OP_LDI, OP_STI};
    endfunction

    function automatic logic op_is_ind(input logic [3:0] op);
        return op inside {OP_LDI, OP_STI};
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_ST, OP_STR, OP_STI};
    endfunction

    // Handshake: complete_instr is sampled only in FETCH and complete_data only in MEM;
    // a high level at a rising edge in that state ends the wait, and is ignored elsewhere.
`ifdef LC3_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt_q;
    logic       waiting;

    assign waiting = ((state_q == S_FETCH) && !complete_instr) ||
                     ((state_q == S_MEM) && !complete_data);
    assign wait_expired = waiting && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // Any cycle that is not a continuing wait clears the counter, so every FETCH and
    // every MEM phase starts counting from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else if (waiting && !wait_expired) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wait_expired       = 1'b0;
    assign unused_timeout_cfg = ^(8'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d   = state_q;
        ind_d     = ind_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (complete_instr) begin
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d   = S_UPC;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                op_d = exec_op;
                if (op_is_alu(exec_op)) begin
                    state_d = S_WB;
                end else if (op_is_mem(exec_op)) begin
                    state_d = S_MEM;
                    ind_d   = op_is_ind(exec_op);
                end else begin
                    state_d   = S_UPC;
                    illegal_d = (exec_op != OP_BR) && (exec_op != OP_JMP);
                end
            end
            S_MEM: begin
                if (complete_data) begin
                    if (ind_q) begin
                        ind_d = 1'b0;
                    end else if (op_is_store(op_q)) begin
                        state_d = S_UPC;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d   = S_UPC;
                    ind_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            S_WB:    state_d = S_UPC;
            S_UPC:   state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ind_q     <= 1'b0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ind_q     <= ind_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign enable_fetch     = (state_q == S_FETCH);
    assign enable_decode    = (state_q == S_DECODE);
    assign enable_execute   = (state_q == S_EXEC);
    assign enable_writeback = (state_q == S_WB);
    assign enable_updatePC  = (state_q == S_UPC);
    assign illegal_op       = illegal_q;
    assign timeout          = timeout_q;
    assign dbg_state        = state_q;

    // A timed-out UPC carries a stale opcode, so it must never redirect the PC.
    assign br_taken = (state_q == S_UPC) && !timeout_q &&
                      (((op_q == OP_BR) && |(IR_Exec[11:9] & NZP)) || (op_q == OP_JMP));

    always_comb begin
        mem_state = 2'd3;
        if (state_q == S_MEM) begin
            if (ind_q) begin
                mem_state = 2'd1;
            end else if (op_is_store(op_q)) begin
                mem_state = 2'd2;
            end else begin
                mem_state = 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_controller.sv
// Bench for lc3_controller: per-instruction cycle timelines from an opcode-level model,
// compared cycle by cycle against the DUT outputs.
module tb_lc3_controller;

    localparam int TIMEOUT = 16;
`ifdef LC3_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_F    = 5'b10000;
    localparam logic [4:0] EN_D    = 5'b01000;
    localparam logic [4:0] EN_E    = 5'b00100;
    localparam logic [4:0] EN_W    = 5'b00010;
    localparam logic [4:0] EN_U    = 5'b00001;
    localparam logic [9:0] RESET_OBS = {EN_NONE, 1'b0, 2'd3, 1'b0, 1'b0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        complete_instr = 1'b0;
    logic        complete_data = 1'b0;
    logic [15:0] IR = '0;
    logic [15:0] IR_Exec = '0;
    logic [2:0]  NZP = '0;
    logic [2:0]  psr = '0;
    logic [15:0] IMem_dout = '0;
    logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
    logic        br_taken, illegal_op, timeout;
    logic [1:0]  mem_state;
    logic [2:0]  dbg_state;
    logic [9:0]  obs;

    logic [9:0]  exp_q[$];
    logic [1:0]  drv_q[$];
    logic [15:0] ir_q[$];
    logic [2:0]  nzp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    lc3_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .IR(IR), .IR_Exec(IR_Exec), .NZP(NZP), .psr(psr), .IMem_dout(IMem_dout),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_execute(enable_execute), .enable_writeback(enable_writeback),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken), .mem_state(mem_state),
        .illegal_op(illegal_op), .timeout(timeout), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    assign obs = {enable_fetch, enable_decode, enable_execute, enable_writeback,
                  enable_updatePC, br_taken, mem_state, illegal_op, timeout};

    function automatic logic [9:0] mk(input logic [4:0] en, input logic br, input logic [1:0] ms,
                                      input logic ill, input logic to);
        return {en, br, ms, ill, to};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [9:0] e, input logic ci, input logic cd,
                        input logic [15:0] ir, input logic [2:0] nzp);
        exp_q.push_back(e);
        drv_q.push_back({ci, cd});
        ir_q.push_back(ir);
        nzp_q.push_back(nzp);
    endtask

    // w low cycles of the relevant complete, then one high cycle (or a timeout UPC).
    task automatic push_wait(input bit is_fetch, input int w, input logic [9:0] e,
                             input logic [15:0] ir, input logic [2:0] nzp, output bit expired);
        int n;
        expired = TO_EN && (w >= TIMEOUT);
        n = expired ? TIMEOUT : w;
        for (int i = 0; i < n; i++) begin
            if (is_fetch) push(e, 1'b0, rnd(), ir, nzp);
            else push(e, rnd(), 1'b0, ir, nzp);
        end
        if (expired) push(mk(EN_U, 1'b0, 2'd3, 1'b0, 1'b1), rnd(), rnd(), ir, nzp);
        else if (is_fetch) push(e, 1'b1, rnd(), ir, nzp);
        else push(e, rnd(), 1'b1, ir, nzp);
    endtask

    task automatic model_instr(input logic [15:0] ir, input logic [2:0] nzp,
                               input int fw, input int dw0, input int dw1);
        logic [3:0] op;
        bit is_alu, is_load, is_store, is_ind, is_flow, exp_br, exp_ill, expired;
        op       = ir[15:12];
        is_alu   = op inside {4'h1, 4'h5, 4'h9, 4'hE};
        is_load  = op inside {4'h2, 4'h6, 4'hA};
        is_store = op inside {4'h3, 4'h7, 4'hB};
        is_ind   = op inside {4'hA, 4'hB};
        is_flow  = op inside {4'h0, 4'hC};
        exp_ill  = !(is_alu || is_load || is_store || is_flow);
        exp_br   = (op == 4'h0) ? |(ir[11:9] & nzp) : (op == 4'hC);
        push_wait(1'b1, fw, mk(EN_F, 1'b0, 2'd3, 1'b0, 1'b0), ir, nzp, expired);
        if (expired) return;
        push(mk(EN_D, 1'b0, 2'd3, 1'b0, 1'b0), rnd(), rnd(), ir, nzp);
        push(mk(EN_E, 1'b0, 2'd3, 1'b0, 1'b0), rnd(), rnd(), ir, nzp);
        if (is_load || is_store) begin
            if (is_ind) begin
                push_wait(1'b0, dw0, mk(EN_NONE, 1'b0, 2'd1, 1'b0, 1'b0), ir, nzp, expired);
                if (expired) return;
            end
            push_wait(1'b0, is_ind ? dw1 : dw0,
                      mk(EN_NONE, 1'b0, is_store ? 2'd2 : 2'd0, 1'b0, 1'b0), ir, nzp, expired);
            if (expired) return;
        end
        if (is_alu || is_load) push(mk(EN_W, 1'b0, 2'd3, 1'b0, 1'b0), rnd(), rnd(), ir, nzp);
        push(mk(EN_U, exp_br, 2'd3, exp_ill, 1'b0), rnd(), rnd(), ir, nzp);
    endtask

    task automatic run_n(input string name, input int max_cycles);
        int idx;
        logic [9:0] e;
        logic [1:0] d;
        idx = 0;
        while (exp_q.size() > 0 && idx < max_cycles) begin
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            @(posedge clock);
            #1;
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d: outputs got %b expected %b", name, idx, obs, e);
            end
            {complete_instr, complete_data} = d;
            IR_Exec   = ir_q.pop_front();
            NZP       = nzp_q.pop_front();
            IR        = 16'($urandom);
            psr       = 3'($urandom);
            IMem_dout = 16'($urandom);
            idx++;
        end
    endtask

    task automatic run_queue(input string name);
        run_n(name, 1000000);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_errors++;
            $display("FAIL reset_state: outputs got %b expected %b", obs, RESET_OBS);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_errors++;
            $display("FAIL reset_release_idle: outputs got %b expected %b", obs, RESET_OBS);
        end
    endtask

    task automatic test_alu();
        model_instr(16'h1042, 3'($urandom), 0, 0, 0);
        model_instr({4'h5, 12'($urandom)}, 3'($urandom), $urandom_range(0, 2), 0, 0);
        model_instr({4'h9, 12'($urandom)}, 3'($urandom), $urandom_range(0, 2), 0, 0);
        model_instr({4'hE, 12'($urandom)}, 3'($urandom), $urandom_range(0, 2), 0, 0);
        run_queue("alu");
    endtask

    task automatic test_load_store();
        model_instr(16'h2205, 3'b001, 0, 3, 0);
        model_instr(16'h3205, 3'b001, 0, 3, 0);
        model_instr({4'h6, 12'($urandom)}, 3'($urandom), 0, $urandom_range(0, 4), 0);
        model_instr({4'h7, 12'($urandom)}, 3'($urandom), 0, $urandom_range(0, 4), 0);
        run_queue("load_store");
    endtask

    task automatic test_indirect();
        model_instr(16'hA200, 3'b010, 0, 0, 0);
        model_instr(16'hB200, 3'b010, 0, 0, 0);
        model_instr(16'hA200, 3'b100, 1, $urandom_range(1, 4), $urandom_range(1, 4));
        model_instr(16'hB200, 3'b100, 1, $urandom_range(1, 4), $urandom_range(1, 4));
        run_queue("indirect");
    endtask

    task automatic test_branch();
        model_instr(16'h0402, 3'b010, 0, 0, 0);
        model_instr(16'h0402, 3'b100, 0, 0, 0);
        model_instr(16'hC1C0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            model_instr({4'h0, 12'($urandom)}, 3'($urandom), $urandom_range(0, 2), 0, 0);
        run_queue("branch");
    endtask

    task automatic test_illegal();
        model_instr(16'hF025, 3'b111, 0, 0, 0);
        model_instr(16'h8000, 3'b111, 0, 0, 0);
        model_instr(16'hD123, 3'($urandom), 1, 0, 0);
        model_instr(16'h4ABC, 3'($urandom), 0, 0, 0);
        run_queue("illegal");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            model_instr(16'($urandom), 3'($urandom), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
        run_queue("back_to_back");
    endtask

    // Long stalls: with the timeout build these expire, otherwise the FSM keeps waiting.
    task automatic test_long_wait();
        model_instr(16'h3205, 3'b000, 0, 100, 0);
        model_instr(16'hC1C0, 3'b000, 0, 0, 0);
        model_instr(16'h1042, 3'b000, 20, 0, 0);
        model_instr(16'hA200, 3'b000, 0, 2, 30);
        run_queue("long_wait");
    endtask

    task automatic test_reset_mid_mem();
        model_instr(16'h2205, 3'b000, 0, 50, 0);
        run_n("reset_mid_mem_pre", 5);
        exp_q.delete();
        drv_q.delete();
        ir_q.delete();
        nzp_q.delete();
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_errors++;
            $display("FAIL reset_async: outputs got %b expected %b", obs, RESET_OBS);
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_errors++;
            $display("FAIL reset_hold: outputs got %b expected %b", obs, RESET_OBS);
        end
        @(negedge clock);
        reset = 1'b1;
        model_instr(16'h1042, 3'b000, 0, 0, 0);
        model_instr(16'h3205, 3'b000, 0, 1, 0);
        run_queue("after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_indirect();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_long_wait();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
